debouncer_bank: RTL and testbench

Parametrised multi-channel debouncer for the traffic controller's raw field inputs (pedestrian push-buttons, vehicle loop sensors, manual override switch). Each channel synchronises its asynchronous input, filters bounce with a programmable stability window, and produces a clean level, single-cycle rise/fall pulses and a long-press "held" flag. It sits between the board pins and the controller FSM and replaces per-input single-channel debouncing.

---
 rtl/debouncer_bank.sv | 157 +++++++++++++++
 tb/tb_debouncer_bank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_bank.sv
// debouncer_bank: multi-channel input debouncer for the traffic controller's
// field inputs. Each channel synchronises its raw pin, waits for the new level
// to persist for STABLE_CYCLES, then updates a clean level, fires one-cycle
// rise/fall pulses and raises a long-press "held" flag after HOLD_CYCLES.

// One debounced channel: 2-flop synchroniser, stability filter, hold timer.
module debouncer_channel #(
    parameter int   CNT_W         = 16,
    parameter int   STABLE_CYCLES = 50000,
    parameter int   HOLD_W        = 24,
    parameter int   HOLD_CYCLES   = 5000000,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic held
);

    // Terminal counts: the window closes when the counter has already seen
    // N-1 mismatching cycles and the current cycle still mismatches.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic              sync1;
    logic              sync2;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              clean_next;
    logic              rise_next;
    logic              fall_next;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] hcnt_next;
    logic              held_next;

    // Two-flop synchroniser bringing the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= noisy;
            sync2 <= sync1;
        end
    end

    // Stability filter: any cycle agreeing with clean restarts the window;
    // the level only commits after STABLE_CYCLES consecutive disagreements.
    always_comb begin
        cnt_next   = cnt;
        clean_next = clean;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (sync2 == clean) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            clean_next = sync2;
            rise_next  = sync2;
            fall_next  = ~sync2;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // Hold timer: counts while clean is high, saturates by freezing once held
    // is set, and clears as soon as it observes clean low (one edge after fall).
    always_comb begin
        hcnt_next = hcnt;
        held_next = held;
        if (!clean) begin
            hcnt_next = '0;
            held_next = 1'b0;
        end else if (!held) begin
            if (hcnt == HOLD_LAST) begin
                held_next = 1'b1;
            end else begin
                hcnt_next = hcnt + HOLD_W'(1);
            end
        end
    end

    // Stability counter, clean level and registered edge pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            clean <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            clean <= clean_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // Hold counter and long-press flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt <= '0;
            held <= 1'b0;
        end else begin
            hcnt <= hcnt_next;
            held <= held_next;
        end
    end

endmodule

// Bank of independent channels plus a combined change indicator.
module debouncer_bank #(
    parameter int                  CHANNELS      = 4,
    parameter int                  CNT_W         = 16,
    parameter int                  STABLE_CYCLES = 50000,
    parameter int                  HOLD_W        = 24,
    parameter int                  HOLD_CYCLES   = 5000000,
    parameter logic [CHANNELS-1:0] RESET_VAL     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] held,
    output logic                any_change
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debouncer_channel #(
            .CNT_W         (CNT_W),
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_W        (HOLD_W),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .noisy (noisy[i]),
            .clean (clean[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .held  (held[i])
        );
    end

    // Pulses are already registered, so this OR stays glitch-free and is
    // high exactly while any channel shows an edge pulse.
    always_comb begin
        any_change = |(rise | fall);
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// tb_debouncer_bank: directed stimulus with hand-computed expected output
// events queued per cycle; a negedge monitor pops and compares whenever the
// DUT shows a pulse or a change of clean/held.

module tb_debouncer_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] noisy;
    logic [3:0] clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] held;
    logic       any_change;

    int cyc = 0;
    int n_vec = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] held;
    } evt_t;

    evt_t       exp_q[$];
    evt_t       cur_exp;
    logic [3:0] prev_clean = 4'b0000;
    logic [3:0] prev_held  = 4'b0000;
    logic       exp_any;

    debouncer_bank #(
        .CHANNELS      (4),
        .CNT_W         (8),
        .STABLE_CYCLES (4),
        .HOLD_W        (8),
        .HOLD_CYCLES   (8),
        .RESET_VAL     (4'b0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .noisy      (noisy),
        .clean      (clean),
        .rise       (rise),
        .fall       (fall),
        .held       (held),
        .any_change (any_change)
    );

    // Free-running clock and cycle counter (cyc = number of rising edges seen).
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] v, output int c);
        noisy = v;
        c = cyc;
    endtask

    task automatic expect_evt(input int c, input logic [3:0] cl, input logic [3:0] r,
                              input logic [3:0] f, input logic [3:0] h);
        evt_t e;
        e.cyc   = c;
        e.clean = cl;
        e.rise  = r;
        e.fall  = f;
        e.held  = h;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    // Monitor: flags events that were expected but never seen, then compares
    // every observed output event against the head of the queue.
    always @(negedge clk) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL missed_event: expected at cycle %0d, nothing seen by cycle %0d",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (any_change || (|rise) || (|fall) || clean !== prev_clean || held !== prev_held) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_event: cycle %0d clean=%b rise=%b fall=%b held=%b any=%b, none expected",
                             cyc, clean, rise, fall, held, any_change);
                end else begin
                    cur_exp = exp_q.pop_front();
                    exp_any = |(cur_exp.rise | cur_exp.fall);
                    if (cur_exp.cyc != cyc || cur_exp.clean !== clean || cur_exp.rise !== rise ||
                        cur_exp.fall !== fall || cur_exp.held !== held || exp_any !== any_change) begin
                        n_fail++;
                        $display("[TB] FAIL event: got cyc=%0d clean=%b rise=%b fall=%b held=%b any=%b, need cyc=%0d clean=%b rise=%b fall=%b held=%b any=%b",
                                 cyc, clean, rise, fall, held, any_change,
                                 cur_exp.cyc, cur_exp.clean, cur_exp.rise, cur_exp.fall, cur_exp.held, exp_any);
                    end
                end
            end
        end
        prev_clean <= clean;
        prev_held  <= held;
    end

    // Directed scenarios; latency is 6 cycles from drive to visible clean
    // change (2 sync flops + 4-cycle window), held follows 8 cycles later.
    initial begin
        int c;
        reset = 1'b0;
        noisy = 4'b0000;
        tick(5);
        check_output("reset_clean", 32'(clean), 32'h0);
        check_output("reset_rise", 32'(rise), 32'h0);
        check_output("reset_fall", 32'(fall), 32'h0);
        check_output("reset_held", 32'(held), 32'h0);
        check_output("reset_any", 32'(any_change), 32'h0);
        reset = 1'b1;
        tick(20);
        check_output("idle_clean", 32'(clean), 32'h0);
        check_output("idle_held", 32'(held), 32'h0);

        // Clean step on ch0, kept pressed long enough to reach held.
        apply_stimulus(4'b0001, c);
        expect_evt(c + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        expect_evt(c + 14, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        tick(20);

        // Bounce on ch1: 3 high / 1 low, ten times, then steady high.
        for (int k = 0; k < 10; k++) begin
            noisy[1] = 1'b1;
            tick(3);
            noisy[1] = 1'b0;
            tick(1);
        end
        apply_stimulus(4'b0011, c);
        expect_evt(c + 6, 4'b0011, 4'b0010, 4'b0000, 4'b0001);
        expect_evt(c + 14, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        tick(20);

        // Long press on ch2, release, then a short 6-cycle press.
        apply_stimulus(4'b0111, c);
        expect_evt(c + 6, 4'b0111, 4'b0100, 4'b0000, 4'b0011);
        expect_evt(c + 14, 4'b0111, 4'b0000, 4'b0000, 4'b0111);
        tick(20);
        apply_stimulus(4'b0011, c);
        expect_evt(c + 6, 4'b0011, 4'b0000, 4'b0100, 4'b0111);
        expect_evt(c + 7, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        tick(12);
        apply_stimulus(4'b0111, c);
        expect_evt(c + 6, 4'b0111, 4'b0100, 4'b0000, 4'b0011);
        expect_evt(c + 12, 4'b0011, 4'b0000, 4'b0100, 4'b0011);
        tick(6);
        noisy[2] = 1'b0;
        tick(14);
        check_output("short_press_held", 32'(held), 32'h3);

        // Simultaneous ch0 fall with ch3 rise, then the reverse.
        apply_stimulus(4'b1010, c);
        expect_evt(c + 6, 4'b1010, 4'b1000, 4'b0001, 4'b0011);
        expect_evt(c + 7, 4'b1010, 4'b0000, 4'b0000, 4'b0010);
        expect_evt(c + 14, 4'b1010, 4'b0000, 4'b0000, 4'b1010);
        tick(20);
        apply_stimulus(4'b0011, c);
        expect_evt(c + 6, 4'b0011, 4'b0001, 4'b1000, 4'b1010);
        expect_evt(c + 7, 4'b0011, 4'b0000, 4'b0000, 4'b0010);
        expect_evt(c + 14, 4'b0011, 4'b0000, 4'b0000, 4'b0011);
        tick(20);

        // Set up for mid-operation reset: ch0 low, ch2 held.
        apply_stimulus(4'b0010, c);
        expect_evt(c + 6, 4'b0010, 4'b0000, 4'b0001, 4'b0011);
        expect_evt(c + 7, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        tick(12);
        apply_stimulus(4'b0110, c);
        expect_evt(c + 6, 4'b0110, 4'b0100, 4'b0000, 4'b0010);
        expect_evt(c + 14, 4'b0110, 4'b0000, 4'b0000, 4'b0110);
        tick(20);
        apply_stimulus(4'b0111, c);
        tick(4);
        reset = 1'b0;
        #1;
        check_output("async_reset_clean", 32'(clean), 32'h0);
        check_output("async_reset_rise", 32'(rise), 32'h0);
        check_output("async_reset_fall", 32'(fall), 32'h0);
        check_output("async_reset_held", 32'(held), 32'h0);
        check_output("async_reset_any", 32'(any_change), 32'h0);
        tick(3);
        reset = 1'b1;
        c = cyc;
        expect_evt(c + 6, 4'b0111, 4'b0111, 4'b0000, 4'b0000);
        expect_evt(c + 14, 4'b0111, 4'b0000, 4'b0000, 4'b0111);
        tick(20);

        check_output("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
